// File: rtl/snn_sched_pkg.sv
// Shared constants and FSM state encoding for the spike scheduler controller.
package snn_sched_pkg;
  localparam int PKT_W   = 12;
  localparam int DELAY_W = 4;
  localparam logic [DELAY_W-1:0] DROP_DELAY = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_PROCESS,
    ST_CLEAR,
    ST_ADVANCE
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority pointer.
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_SRC-1:0] o_gnt
);
  logic w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (!w_found && i_req[j] && (j == ((int'(i_ptr) + k) % NUM_SRC))) begin
          o_gnt[j] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/spike_sched_ctrl.sv
// Timestep controller: sequences the neuron core once per tick and forwards
// round-robin arbitrated axon packets into the spike scheduler.
module spike_sched_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int PKT_W   = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*PKT_W-1:0] src_packet,
  output logic [NUM_SRC-1:0]       src_ready,
  input  logic                     tick,
  output logic                     core_start,
  input  logic                     core_done,
  output logic                     sch_wen,
  output logic                     sch_set,
  output logic                     sch_clr,
  output logic [PKT_W-1:0]         sch_packet,
  input  logic                     sch_error,
  output logic                     busy,
  output logic [15:0]              tick_count,
  output logic [7:0]               drop_count,
  output logic                     err_sticky,
  output logic                     tick_overrun
);
  import snn_sched_pkg::*;

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_t           r_state;
  logic [PTR_W-1:0] r_ptr;
  logic             r_pending;
  logic             r_overrun;
  logic             r_core_start;
  logic             r_sch_wen;
  logic             r_sch_clr;
  logic             r_sch_set;
  logic             r_err;
  logic [PKT_W-1:0] r_sch_packet;
  logic [15:0]      r_tick_count;
  logic [7:0]       r_drop_count;

  logic               w_grant_en;
  logic [NUM_SRC-1:0] w_gnt;
  logic [NUM_SRC-1:0] w_ready;
  logic               w_accept;
  logic               w_drop;
  logic [PKT_W-1:0]   w_sel_pkt;
  logic [PTR_W-1:0]   w_sel_idx;
  logic [PTR_W-1:0]   w_next_ptr;

  rr_arbiter #(.NUM_SRC(NUM_SRC), .PTR_W(PTR_W)) u_arb (
    .i_req (src_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  // Withholding grants in the core_done cycle keeps writes off the CLEAR/ADVANCE cycles.
  assign w_grant_en = (r_state == ST_IDLE) || (r_state == ST_START) ||
                      ((r_state == ST_PROCESS) && !core_done);
  assign w_ready    = w_grant_en ? w_gnt : '0;
  assign w_accept   = |w_ready;

  always_comb begin
    w_sel_pkt = '0;
    w_sel_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_ready[i]) begin
        w_sel_pkt = src_packet[i*PKT_W +: PKT_W];
        w_sel_idx = PTR_W'(i);
      end
    end
  end

  assign w_drop     = (w_sel_pkt[DELAY_W-1:0] == DROP_DELAY);
  assign w_next_ptr = (w_sel_idx == PTR_W'(NUM_SRC - 1)) ? '0 : w_sel_idx + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_pending    <= 1'b0;
      r_overrun    <= 1'b0;
      r_core_start <= 1'b0;
      r_sch_wen    <= 1'b0;
      r_sch_clr    <= 1'b0;
      r_sch_set    <= 1'b0;
      r_err        <= 1'b0;
      r_sch_packet <= '0;
      r_tick_count <= '0;
      r_drop_count <= '0;
    end else begin
      r_core_start <= 1'b0;
      r_sch_clr    <= 1'b0;
      r_sch_set    <= 1'b0;

      // A tick arriving with one already pending stays pending for the next timestep.
      if (r_state == ST_IDLE) begin
        r_pending <= r_pending & tick;
      end else if (tick) begin
        if (r_pending) r_overrun <= 1'b1;
        else           r_pending <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (tick || r_pending) begin
            r_state      <= ST_START;
            r_core_start <= 1'b1;
          end
        end
        ST_START: r_state <= ST_PROCESS;
        ST_PROCESS: begin
          if (core_done) begin
            r_state   <= ST_CLEAR;
            r_sch_clr <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_state      <= ST_ADVANCE;
          r_sch_set    <= 1'b1;
          r_tick_count <= r_tick_count + 16'd1;
        end
        ST_ADVANCE: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase

      r_sch_wen <= w_accept && !w_drop;
      if (w_accept) begin
        r_ptr <= w_next_ptr;
        if (!w_drop)                    r_sch_packet <= w_sel_pkt;
        else if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
      end
      if (r_sch_wen && sch_error) r_err <= 1'b1;
    end
  end

  assign src_ready    = w_ready;
  assign core_start   = r_core_start;
  assign sch_wen      = r_sch_wen;
  assign sch_clr      = r_sch_clr;
  assign sch_set      = r_sch_set;
  assign sch_packet   = r_sch_packet;
  assign busy         = (r_state != ST_IDLE);
  assign tick_count   = r_tick_count;
  assign drop_count   = r_drop_count;
  assign err_sticky   = r_err;
  assign tick_overrun = r_overrun;
endmodule

// File: tb/tb_spike_sched_ctrl.sv
// Self-checking bench for spike_sched_ctrl: scripted timestep scenarios plus
// randomized arbitration traffic checked against a round-robin reference model.
module tb_spike_sched_ctrl;
  localparam int NUM_SRC = 4;
  localparam int PKT_W   = 12;
  localparam int OBS_W   = 7 + NUM_SRC + PKT_W + 24;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC*PKT_W-1:0] src_packet;
  logic [NUM_SRC-1:0]       src_ready;
  logic                     tick;
  logic                     core_start;
  logic                     core_done;
  logic                     sch_wen;
  logic                     sch_set;
  logic                     sch_clr;
  logic [PKT_W-1:0]         sch_packet;
  logic                     sch_error;
  logic                     busy;
  logic [15:0]              tick_count;
  logic [7:0]               drop_count;
  logic                     err_sticky;
  logic                     tick_overrun;

  int checks = 0;
  int errors = 0;
  logic [PKT_W-1:0] pkts [NUM_SRC];

  always #5 clk = ~clk;

  spike_sched_ctrl #(.NUM_SRC(NUM_SRC), .PKT_W(PKT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .src_valid    (src_valid),
    .src_packet   (src_packet),
    .src_ready    (src_ready),
    .tick         (tick),
    .core_start   (core_start),
    .core_done    (core_done),
    .sch_wen      (sch_wen),
    .sch_set      (sch_set),
    .sch_clr      (sch_clr),
    .sch_packet   (sch_packet),
    .sch_error    (sch_error),
    .busy         (busy),
    .tick_count   (tick_count),
    .drop_count   (drop_count),
    .err_sticky   (err_sticky),
    .tick_overrun (tick_overrun)
  );

  function automatic logic [OBS_W-1:0] all_outputs();
    return {core_start, sch_wen, sch_set, sch_clr, busy, err_sticky, tick_overrun,
            src_ready, sch_packet, tick_count, drop_count};
  endfunction

  function automatic logic [PKT_W-1:0] rand_pkt(input bit drop);
    logic [PKT_W-1:0] p;
    p = PKT_W'($urandom);
    if (drop) p[3:0] = 4'hF;
    else if (p[3:0] == 4'hF) p[3:0] = 4'($urandom_range(0, 14));
    return p;
  endfunction

  task automatic drive_pkts();
    for (int i = 0; i < NUM_SRC; i++) src_packet[i*PKT_W +: PKT_W] = pkts[i];
  endtask

  function automatic int rr_pick(input logic [NUM_SRC-1:0] v, input int ptr);
    int j;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = (ptr + k) % NUM_SRC;
      if (((v >> j) & NUM_SRC'(1)) != '0) return j;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; tick = 1'b0; core_done = 1'b0; sch_error = 1'b0;
    src_valid = '0; src_packet = '0;
    for (int i = 0; i < NUM_SRC; i++) pkts[i] = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (all_outputs() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %0h expected 0", all_outputs());
    end
  endtask

  task automatic test_alternate();
    int exp_idx;
    logic [NUM_SRC-1:0] exp_ready;
    do_reset();
    src_valid = 4'b0101;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NUM_SRC; i++) pkts[i] = rand_pkt(1'b0);
      drive_pkts();
      #1;
      exp_idx   = (c % 2 == 0) ? 0 : 2;
      exp_ready = NUM_SRC'(1) << exp_idx;
      checks++;
      if (src_ready !== exp_ready) begin
        errors++; $display("FAIL alt_grant[%0d]: got %b expected %b", c, src_ready, exp_ready);
      end
      @(negedge clk);
      checks++;
      if (sch_wen !== 1'b1 || sch_packet !== pkts[exp_idx]) begin
        errors++; $display("FAIL alt_write[%0d]: got wen=%b pkt=%h expected wen=1 pkt=%h",
                           c, sch_wen, sch_packet, pkts[exp_idx]);
      end
    end
    src_valid = '0;
  endtask

  task automatic test_timestep();
    do_reset();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checks++;
    if (core_start !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL ts_start: got core_start=%b busy=%b expected 1 1", core_start, busy);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (core_start !== 1'b0 || busy !== 1'b1 || sch_clr !== 1'b0) begin
        errors++; $display("FAIL ts_process[%0d]: got start=%b busy=%b clr=%b expected 0 1 0",
                           k, core_start, busy, sch_clr);
      end
      if (k == 5) core_done = 1'b1;
    end
    @(negedge clk);
    core_done = 1'b0;
    checks++;
    if (sch_clr !== 1'b1 || sch_set !== 1'b0 || sch_wen !== 1'b0) begin
      errors++; $display("FAIL ts_clear: got clr=%b set=%b wen=%b expected 1 0 0", sch_clr, sch_set, sch_wen);
    end
    @(negedge clk);
    checks++;
    if (sch_set !== 1'b1 || sch_clr !== 1'b0 || tick_count !== 16'd1) begin
      errors++; $display("FAIL ts_advance: got set=%b clr=%b tc=%0d expected 1 0 1", sch_set, sch_clr, tick_count);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sch_set !== 1'b0 || tick_count !== 16'd1) begin
      errors++; $display("FAIL ts_idle: got busy=%b set=%b tc=%0d expected 0 0 1", busy, sch_set, tick_count);
    end
  endtask

  task automatic test_drop();
    int exp_cnt;
    bit wen_seen;
    do_reset();
    src_valid = 4'b0010;
    pkts[1]   = 12'h0AF;
    drive_pkts();
    #1;
    checks++;
    if (src_ready !== 4'b0010) begin
      errors++; $display("FAIL drop_grant: got %b expected 0010", src_ready);
    end
    wen_seen = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (sch_wen !== 1'b0) wen_seen = 1'b1;
      exp_cnt = (n > 255) ? 255 : n;
      checks++;
      if (drop_count !== 8'(exp_cnt)) begin
        errors++; $display("FAIL drop_count[%0d]: got %0d expected %0d", n, drop_count, exp_cnt);
      end
    end
    src_valid = '0;
    checks++;
    if (wen_seen || sch_packet !== '0) begin
      errors++; $display("FAIL drop_no_write: got wen_seen=%b pkt=%h expected 0 0", wen_seen, sch_packet);
    end
  endtask

  task automatic test_no_grant_done();
    bit gok [8] = '{1, 1, 1, 1, 0, 0, 0, 1};
    bit dn  [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    bit prev_grant;
    logic [PKT_W-1:0] prev_pkt;
    logic [NUM_SRC-1:0] exp_ready;
    do_reset();
    src_valid  = 4'b0010;
    prev_grant = 1'b0;
    prev_pkt   = '0;
    for (int c = 0; c < 8; c++) begin
      pkts[1] = rand_pkt(1'b0);
      drive_pkts();
      tick      = (c == 0);
      core_done = dn[c];
      #1;
      exp_ready = gok[c] ? 4'b0010 : 4'b0000;
      checks++;
      if (src_ready !== exp_ready) begin
        errors++; $display("FAIL busy_grant[%0d]: got %b expected %b", c, src_ready, exp_ready);
      end
      checks++;
      if (sch_wen !== prev_grant || (prev_grant && sch_packet !== prev_pkt) ||
          sch_clr !== (c == 5) || sch_set !== (c == 6)) begin
        errors++; $display("FAIL busy_write[%0d]: got wen=%b pkt=%h clr=%b set=%b expected wen=%b pkt=%h",
                           c, sch_wen, sch_packet, sch_clr, sch_set, prev_grant, prev_pkt);
      end
      prev_grant = gok[c];
      if (gok[c]) prev_pkt = pkts[1];
      @(negedge clk);
    end
    src_valid = '0; tick = 1'b0; core_done = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    checks++;
    if (tick_overrun !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL ovr_pending: got ovr=%b busy=%b expected 0 1", tick_overrun, busy);
    end
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checks++;
    if (tick_overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_flag: got %b expected 1", tick_overrun);
    end
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    @(negedge clk);
    checks++;
    if (sch_set !== 1'b1 || tick_count !== 16'd1) begin
      errors++; $display("FAIL ovr_first_adv: got set=%b tc=%0d expected 1 1", sch_set, tick_count);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL ovr_idle: got busy=%b expected 0", busy);
    end
    @(negedge clk);
    checks++;
    if (core_start !== 1'b1) begin
      errors++; $display("FAIL ovr_restart: got core_start=%b expected 1", core_start);
    end
    @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tick_count !== 16'd2 || tick_overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_final: got busy=%b tc=%0d ovr=%b expected 0 2 1", busy, tick_count, tick_overrun);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || sch_clr !== 1'b0) begin
      errors++; $display("FAIL stray_done: got busy=%b clr=%b expected 0 0", busy, sch_clr);
    end
    src_valid = 4'b0010;
    pkts[1]   = rand_pkt(1'b1);
    drive_pkts();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0; src_valid = '0;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checks++;
    if (busy !== 1'b1 || drop_count !== 8'd1) begin
      errors++; $display("FAIL rst_pre: got busy=%b drops=%0d expected 1 1", busy, drop_count);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (all_outputs() !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got %0h expected 0", all_outputs());
    end
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      core_done = (k == 1);
      @(negedge clk);
      checks++;
      if (sch_clr !== 1'b0 || sch_set !== 1'b0 || busy !== 1'b0 || core_start !== 1'b0) begin
        errors++; $display("FAIL rst_abandon[%0d]: got clr=%b set=%b busy=%b start=%b expected 0 0 0 0",
                           k, sch_clr, sch_set, busy, core_start);
      end
    end
    core_done = 1'b0;
  endtask

  task automatic test_random();
    int ptr_m, pick, n_drop;
    bit exp_wen, err_m, err_in;
    logic [PKT_W-1:0] last_pkt;
    logic [NUM_SRC-1:0] exp_ready;
    do_reset();
    ptr_m = 0; n_drop = 0; exp_wen = 1'b0; err_m = 1'b0; last_pkt = '0;
    for (int c = 0; c < 200; c++) begin
      checks++;
      if (sch_wen !== exp_wen || sch_packet !== last_pkt) begin
        errors++; $display("FAIL rnd_write[%0d]: got wen=%b pkt=%h expected wen=%b pkt=%h",
                           c, sch_wen, sch_packet, exp_wen, last_pkt);
      end
      checks++;
      if (drop_count !== 8'((n_drop > 255) ? 255 : n_drop) || err_sticky !== err_m) begin
        errors++; $display("FAIL rnd_status[%0d]: got drops=%0d err=%b expected drops=%0d err=%b",
                           c, drop_count, err_sticky, n_drop, err_m);
      end
      err_in    = ($urandom_range(0, 7) == 0);
      sch_error = err_in;
      err_m     = err_m | (exp_wen & err_in);
      src_valid = NUM_SRC'($urandom);
      for (int i = 0; i < NUM_SRC; i++) pkts[i] = rand_pkt($urandom_range(0, 3) == 0);
      drive_pkts();
      #1;
      pick      = rr_pick(src_valid, ptr_m);
      exp_ready = (pick < 0) ? '0 : NUM_SRC'(1) << pick;
      checks++;
      if (src_ready !== exp_ready) begin
        errors++; $display("FAIL rnd_grant[%0d]: got %b expected %b", c, src_ready, exp_ready);
      end
      exp_wen = 1'b0;
      if (pick >= 0) begin
        ptr_m = (pick + 1) % NUM_SRC;
        if (pkts[pick][3:0] == 4'hF) n_drop++;
        else begin
          exp_wen  = 1'b1;
          last_pkt = pkts[pick];
        end
      end
      @(negedge clk);
    end
    src_valid = '0; sch_error = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_timestep();
    test_drop();
    test_no_grant_done();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spike_sched_ctrl.md
SPIKE_SCHED_CTRL -- requirements
Module: spike_sched_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of packet requesters.
REQ-002 SHALL have parameter PKT_W, default 12, packet width; bits [3:0] are the delay field, bits [11:4] the axon index.
REQ-003 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports src_valid  in  NUM_SRC and src_packet  in  NUM_SRC*PKT_W: per-requester packet offer; slice i is bits [i*PKT_W +: PKT_W].
REQ-006 SHALL have port src_ready  out  NUM_SRC  one-hot-or-zero grant; transfer on valid&ready.
REQ-007 SHALL have port tick  in  1  timestep request pulse.
REQ-008 SHALL have ports core_start  out  1 (one-cycle pulse) and core_done  in  1 (one-cycle pulse): neuron core handshake.
REQ-009 SHALL have ports sch_wen, sch_set, sch_clr  out  1 each, and sch_packet  out  PKT_W: spike scheduler controls.
REQ-010 SHALL have port sch_error  in  1  scheduler slot-collision flag.
REQ-011 SHALL have ports busy  out  1, tick_count  out  16, drop_count  out  8, err_sticky  out  1, tick_overrun  out  1.

Function
REQ-012 SHALL implement FSM IDLE, START, PROCESS, CLEAR, ADVANCE.
REQ-013 IDLE: on tick or pending tick -> START; else stay.
REQ-014 START: core_start=1 for exactly this cycle; -> PROCESS.
REQ-015 PROCESS: wait for core_done; on core_done -> CLEAR.
REQ-016 CLEAR: sch_clr=1 for one cycle, sch_wen=0; -> ADVANCE.
REQ-017 ADVANCE: sch_set=1 for one cycle, sch_wen=0; tick_count increments (wraps 16'hFFFF->0); -> IDLE.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 Grants SHALL be issued only in IDLE, START, PROCESS, and not in the PROCESS cycle where core_done=1.
REQ-020 Arbitration SHALL be round-robin, at most one grant per cycle; after granting i, highest priority moves to (i+1) mod NUM_SRC; pointer resets to 0.
REQ-021 src_ready SHALL be combinational from src_valid, state and pointer.
REQ-022 An accepted packet with delay field != 4'hF SHALL appear on sch_packet with sch_wen=1 exactly one cycle after acceptance.
REQ-023 An accepted packet with delay field 4'hF SHALL be dropped (no sch_wen), and drop_count SHALL increment, saturating at 8'hFF.
REQ-024 sch_wen SHALL never be asserted in the same cycle as sch_clr or sch_set.
REQ-025 sch_packet SHALL hold its last value when sch_wen=0.
REQ-026 err_sticky SHALL set when sch_wen=1 and sch_error=1, and clear only on reset.
REQ-027 tick outside IDLE SHALL set a one-deep pending flag, consumed on the next IDLE->START; tick while pending already set SHALL set tick_overrun (sticky) and be discarded.
REQ-028 tick in IDLE in the same cycle as a grant SHALL both take effect: write completes in START cycle.
REQ-029 core_done outside PROCESS SHALL be ignored.

Reset
REQ-030 reset_n=0 at a clock edge SHALL force IDLE, pointer 0, pending 0, write register empty, all outputs 0, counters 0, sticky flags 0.
REQ-031 Reset mid-timestep SHALL abandon the sequence without emitting sch_clr or sch_set.

Structure
REQ-032 Package snn_sched_pkg SHALL hold PKT_W, DELAY_W=4, the drop delay value 4'hF, and the FSM state enum.
REQ-033 Round-robin grant logic SHALL be sub-module rr_arbiter (NUM_SRC parameter, req/ptr in, one-hot grant out).

Verification
REQ-034 Sources 0,2 valid continuously in IDLE -> grants alternate 0,2,0,2; sch_wen one cycle after each grant with matching packet.
REQ-035 tick in IDLE, core_done 5 cycles after core_start -> core_start 1 cycle, then sch_clr, then sch_set on consecutive cycles; tick_count=1.
REQ-036 Packet 12'h0AF accepted -> no sch_wen, drop_count=1; 300 such packets -> drop_count=8'hFF.
REQ-037 Source 1 valid through PROCESS with core_done -> no grant in core_done cycle; no sch_wen during CLEAR or ADVANCE.
REQ-038 Two ticks during PROCESS -> one extra timestep runs after ADVANCE, tick_overrun=1, tick_count=2.
REQ-039 reset_n=0 during PROCESS -> next cycle IDLE, all outputs 0, no sch_clr/sch_set observed.
